// File: rtl/display_scheduler_pkg.sv
// Shared state/view codes and helpers for the seven-segment display scheduler.
package display_scheduler_pkg;

  localparam int W_DEF = 9;

  typedef enum logic [2:0] {
    S_TIME  = 3'd0,
    S_DATE  = 3'd1,
    S_STW   = 3'd2,
    S_ALARM = 3'd3,
    S_SET   = 3'd4,
    S_RING  = 3'd5
  } state_t;

  localparam logic [1:0] VIEW_TIME  = 2'd0;
  localparam logic [1:0] VIEW_STW   = 2'd1;
  localparam logic [1:0] VIEW_ALARM = 2'd2;
  localparam logic [1:0] VIEW_SET   = 2'd3;

  function automatic state_t view_target(input logic [1:0] view);
    case (view)
      VIEW_STW:   return S_STW;
      VIEW_ALARM: return S_ALARM;
      VIEW_SET:   return S_SET;
      default:    return S_TIME;
    endcase
  endfunction

  // DATE belongs to the time view so rotation is not mistaken for a view change.
  function automatic logic in_view(input state_t s, input logic [1:0] view);
    case (s)
      S_TIME, S_DATE: return view == VIEW_TIME;
      S_STW:          return view == VIEW_STW;
      S_ALARM:        return view == VIEW_ALARM;
      S_SET:          return view == VIEW_SET;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Control, source-value and display signals between the scheduler and its neighbours.
interface display_scheduler_if #(parameter int W = 9);
  logic         tick_1hz;
  logic [1:0]   view_sel;
  logic         alarm_ring;
  logic         ring_ack;
  logic         lap_pulse;
  logic         set_field_L;
  logic [W-1:0] time_hr, time_min, date_mon, date_day;
  logic [W-1:0] stw_min, stw_sec, alm_hr, alm_min, set_L, set_R;
  logic [W-1:0] disp_L, disp_R;
  logic         blank_L, blank_R;
  logic [2:0]   src_sel;
  logic         lap_active;
  logic         ring_timeout;

  modport master (
    output tick_1hz, view_sel, alarm_ring, ring_ack, lap_pulse, set_field_L,
           time_hr, time_min, date_mon, date_day, stw_min, stw_sec,
           alm_hr, alm_min, set_L, set_R,
    input  disp_L, disp_R, blank_L, blank_R, src_sel, lap_active, ring_timeout
  );

  modport slave (
    input  tick_1hz, view_sel, alarm_ring, ring_ack, lap_pulse, set_field_L,
           time_hr, time_min, date_mon, date_day, stw_min, stw_sec,
           alm_hr, alm_min, set_L, set_R,
    output disp_L, disp_R, blank_L, blank_R, src_sel, lap_active, ring_timeout
  );
endinterface

// File: rtl/display_scheduler_dwell_timer.sv
// Tick-enabled saturating dwell counter; match flags the last tick of a dwell of 'limit' ticks.
module disp_dwell_timer #(
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          tick,
  input  logic [CW-1:0] limit,
  output logic          match
);

  logic [CW-1:0] cnt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (tick) cnt <= sat_inc(cnt);
  end

  assign match = (cnt == limit - CW'(1));

endmodule

// File: rtl/display_scheduler.sv
// Chooses which source pair drives the 4-digit display: time/date rotation, stopwatch
// with lap freeze, alarm, edit view with field blink, and a preempting ring view.
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int TIME_DWELL = 8,
  parameter int DATE_DWELL = 2,
  parameter int RING_MAX   = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  display_scheduler_if.slave bus
);

  localparam int MAX_AB = (TIME_DWELL > DATE_DWELL) ? TIME_DWELL : DATE_DWELL;
  localparam int MAXP   = (MAX_AB > RING_MAX) ? MAX_AB : RING_MAX;
  localparam int CW     = $clog2(MAXP) + 1;

  state_t        state, state_next, target;
  logic          ring_prev, rise, changed;
  logic          blink_ph, blink_next;
  logic          lap_next;
  logic [W-1:0]  lap_min, lap_sec, lap_min_next, lap_sec_next;
  logic [W-1:0]  disp_L_next, disp_R_next;
  logic          blank_L_next, blank_R_next, timeout_next;
  logic          dwell_match;
  logic [CW-1:0] dwell_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_TIME;
    else        state <= state_next;
  end

  always_comb begin
    target       = view_target(bus.view_sel);
    rise         = bus.alarm_ring & ~ring_prev & ~bus.ring_ack;
    state_next   = state;
    timeout_next = 1'b0;
    if (state == S_RING) begin
      if (bus.ring_ack || !bus.alarm_ring) begin
        state_next = target;
      end else if (bus.tick_1hz && dwell_match) begin
        state_next   = target;
        timeout_next = 1'b1;
      end
    end else if (rise) begin
      state_next = S_RING;
    end else if (!in_view(state, bus.view_sel)) begin
      state_next = target;
    end else if (bus.tick_1hz && dwell_match) begin
      if (state == S_TIME)      state_next = S_DATE;
      else if (state == S_DATE) state_next = S_TIME;
    end
  end

  always_comb begin
    case (state)
      S_TIME:  dwell_limit = CW'(TIME_DWELL);
      S_DATE:  dwell_limit = CW'(DATE_DWELL);
      default: dwell_limit = CW'(RING_MAX);
    endcase
  end

  assign changed = (state_next != state);

  disp_dwell_timer #(.CW(CW)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (changed),
    .tick  (bus.tick_1hz),
    .limit (dwell_limit),
    .match (dwell_match)
  );

  // Everything below is computed from the next state so outputs land one clk after the inputs.
  always_comb begin
    blink_next   = blink_ph;
    lap_next     = bus.lap_active;
    lap_min_next = lap_min;
    lap_sec_next = lap_sec;
    blank_L_next = 1'b0;
    blank_R_next = 1'b0;
    disp_L_next  = '0;
    disp_R_next  = '0;

    if (changed)
      blink_next = 1'b0;
    else if (bus.tick_1hz && (state == S_SET || state == S_RING))
      blink_next = ~blink_ph;

    if (state_next != S_STW) begin
      lap_next = 1'b0;
    end else if (state == S_STW && bus.lap_pulse) begin
      lap_next = ~bus.lap_active;
      if (!bus.lap_active) begin
        lap_min_next = bus.stw_min;
        lap_sec_next = bus.stw_sec;
      end
    end

    case (state_next)
      S_TIME: begin disp_L_next = bus.time_hr;  disp_R_next = bus.time_min; end
      S_DATE: begin disp_L_next = bus.date_mon; disp_R_next = bus.date_day; end
      S_STW: begin
        disp_L_next = lap_next ? lap_min_next : bus.stw_min;
        disp_R_next = lap_next ? lap_sec_next : bus.stw_sec;
      end
      S_ALARM: begin disp_L_next = bus.alm_hr; disp_R_next = bus.alm_min; end
      S_SET: begin
        disp_L_next  = bus.set_L;
        disp_R_next  = bus.set_R;
        blank_L_next = bus.set_field_L & blink_next;
        blank_R_next = ~bus.set_field_L & blink_next;
      end
      S_RING: begin
        disp_L_next  = bus.alm_hr;
        disp_R_next  = bus.alm_min;
        blank_L_next = blink_next;
        blank_R_next = blink_next;
      end
      default: begin disp_L_next = '0; disp_R_next = '0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring_prev        <= 1'b0;
      blink_ph         <= 1'b0;
      lap_min          <= '0;
      lap_sec          <= '0;
      bus.lap_active   <= 1'b0;
      bus.disp_L       <= '0;
      bus.disp_R       <= '0;
      bus.blank_L      <= 1'b0;
      bus.blank_R      <= 1'b0;
      bus.src_sel      <= 3'd0;
      bus.ring_timeout <= 1'b0;
    end else begin
      ring_prev        <= bus.alarm_ring;
      blink_ph         <= blink_next;
      lap_min          <= lap_min_next;
      lap_sec          <= lap_sec_next;
      bus.lap_active   <= lap_next;
      bus.disp_L       <= disp_L_next;
      bus.disp_R       <= disp_R_next;
      bus.blank_L      <= blank_L_next;
      bus.blank_R      <= blank_R_next;
      bus.src_sel      <= state_next;
      bus.ring_timeout <= timeout_next;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: rotation, lap freeze, edit blink, ring preempt/timeout, async reset.
module tb_display_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  display_scheduler_if #(.W(9)) bus ();

  display_scheduler #(.W(9), .TIME_DWELL(8), .DATE_DWELL(2), .RING_MAX(60)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.tick_1hz = 1'b1;
    step();
    bus.tick_1hz = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick_1hz = 0; bus.view_sel = 2'd0; bus.alarm_ring = 0; bus.ring_ack = 0;
    bus.lap_pulse = 0; bus.set_field_L = 0;
    bus.time_hr = 9'd12; bus.time_min = 9'd34; bus.date_mon = 9'd5; bus.date_day = 9'd27;
    bus.stw_min = 9'd3; bus.stw_sec = 9'd15; bus.alm_hr = 9'd6; bus.alm_min = 9'd30;
    bus.set_L = 9'd11; bus.set_R = 9'd45;

    // reset state
    step(); step();
    chk("rst_src", bus.src_sel, 0);
    chk("rst_dispL", bus.disp_L, 0);
    chk("rst_dispR", bus.disp_R, 0);
    chk("rst_blank", {bus.blank_L, bus.blank_R}, 0);
    chk("rst_lap", bus.lap_active, 0);
    chk("rst_tmo", bus.ring_timeout, 0);
    rst_n = 1'b1;
    step();
    chk("time_src", bus.src_sel, 0);
    chk("time_disp", {bus.disp_L, bus.disp_R}, {9'd12, 9'd34});

    // 1: time/date rotation
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("rot_src_t%0d", k), bus.src_sel, (k == 8 || k == 9) ? 1 : 0);
      if (k == 8) chk("date_disp", {bus.disp_L, bus.disp_R}, {9'd5, 9'd27});
      if (k == 10) chk("time_back_disp", {bus.disp_L, bus.disp_R}, {9'd12, 9'd34});
      step();
    end

    // 2: stopwatch lap freeze
    bus.view_sel = 2'd1;
    step();
    chk("stw_src", bus.src_sel, 2);
    chk("stw_live", {bus.disp_L, bus.disp_R}, {9'd3, 9'd15});
    bus.lap_pulse = 1; step(); bus.lap_pulse = 0;
    chk("lap_on", bus.lap_active, 1);
    bus.stw_sec = 9'd20;
    step();
    chk("lap_frozen", {bus.disp_L, bus.disp_R}, {9'd3, 9'd15});
    bus.lap_pulse = 1; step(); bus.lap_pulse = 0;
    chk("lap_off", bus.lap_active, 0);
    chk("lap_live", {bus.disp_L, bus.disp_R}, {9'd3, 9'd20});
    bus.lap_pulse = 1; step(); bus.lap_pulse = 0;
    chk("lap_on2", bus.lap_active, 1);
    bus.view_sel = 2'd2;
    step();
    chk("alm_src", bus.src_sel, 3);
    chk("alm_disp", {bus.disp_L, bus.disp_R}, {9'd6, 9'd30});
    chk("lap_leave", bus.lap_active, 0);
    bus.lap_pulse = 1; step(); bus.lap_pulse = 0;
    chk("lap_ignored", bus.lap_active, 0);

    // 3: set view blink on L field
    bus.view_sel = 2'd3; bus.set_field_L = 1;
    step();
    chk("set_src", bus.src_sel, 4);
    chk("set_disp", {bus.disp_L, bus.disp_R}, {9'd11, 9'd45});
    chk("set_blank0", {bus.blank_L, bus.blank_R}, 2'b00);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("set_blankL_t%0d", k), bus.blank_L, k % 2);
      chk($sformatf("set_blankR_t%0d", k), bus.blank_R, 0);
    end

    // 4: ring preempts SET, ack returns to SET with blink cleared
    bus.alarm_ring = 1;
    step();
    chk("ring_src", bus.src_sel, 5);
    chk("ring_disp", {bus.disp_L, bus.disp_R}, {9'd6, 9'd30});
    chk("ring_blank0", {bus.blank_L, bus.blank_R}, 2'b00);
    tick();
    chk("ring_blank1", {bus.blank_L, bus.blank_R}, 2'b11);
    bus.ring_ack = 1; step(); bus.ring_ack = 0;
    chk("ack_src", bus.src_sel, 4);
    chk("ack_blank", {bus.blank_L, bus.blank_R}, 2'b00);
    step();
    chk("ack_no_reentry", bus.src_sel, 4);
    bus.alarm_ring = 0; step();
    bus.alarm_ring = 1; bus.ring_ack = 1; step(); bus.ring_ack = 0;
    chk("ack_beats_rise", bus.src_sel, 4);
    step();
    chk("ack_rise_stay", bus.src_sel, 4);

    // 5: ring timeout with alarm held high
    bus.alarm_ring = 0; bus.view_sel = 2'd0;
    step();
    chk("pre_ring_time", bus.src_sel, 0);
    bus.alarm_ring = 1;
    step();
    chk("ring2_src", bus.src_sel, 5);
    for (int k = 1; k <= 59; k++) begin
      tick();
      step();
    end
    chk("ring_hold59", bus.src_sel, 5);
    chk("tmo_not_yet", bus.ring_timeout, 0);
    tick();
    chk("tmo_pulse", bus.ring_timeout, 1);
    chk("tmo_exit", bus.src_sel, 0);
    step();
    chk("tmo_single", bus.ring_timeout, 0);
    step();
    chk("tmo_no_reentry", bus.src_sel, 0);

    // 6: async reset in the middle of RING
    bus.alarm_ring = 0; bus.view_sel = 2'd1;
    step(); step();
    bus.lap_pulse = 1; step(); bus.lap_pulse = 0;
    chk("pre6_lap", bus.lap_active, 1);
    bus.alarm_ring = 1;
    step();
    chk("pre6_ring", bus.src_sel, 5);
    tick();
    chk("pre6_blank", {bus.blank_L, bus.blank_R}, 2'b11);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_src", bus.src_sel, 0);
    chk("arst_disp", {bus.disp_L, bus.disp_R}, 0);
    chk("arst_blank", {bus.blank_L, bus.blank_R}, 0);
    chk("arst_lap", bus.lap_active, 0);
    chk("arst_tmo", bus.ring_timeout, 0);
    bus.alarm_ring = 0;
    step();
    rst_n = 1'b1;
    step(); step();
    chk("post_rst_src", bus.src_sel, 2);
    chk("post_rst_live", {bus.disp_L, bus.disp_R}, {9'd3, 9'd20});
    chk("post_rst_lap", bus.lap_active, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
